pe_mac_scheduler: RTL and testbench

- Time-shares one single-PE datapath (PE_single plus eight-bit accumulator) between two requesters.
- Each requester streams a dot-product job as (a, b) operand pairs with a last flag.
- The scheduler grants one requester per job with round-robin fairness, clears the accumulator, feeds operands, waits out the datapath latency, then returns the 8-bit result tagged with the requester id.
- Sits between the single-mode/convolution control blocks (requesters) and the PE/accumulator pair.

---
 rtl/pe_mac_scheduler.sv | 173 +++++++++++++++++
 tb/tb_pe_mac_scheduler.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_mac_scheduler.sv
// Round-robin scheduler sharing one PE/accumulator between two dot-product requesters.
// Optional perf counters (job_cnt0/1, busy_cycles) are enabled by defining PE_SCHED_PERF_EN.
module pe_mac_scheduler #(
    parameter int unsigned PIPE_LAT = 2,
    parameter int unsigned MAX_LEN  = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    input  logic [1:0]  req_last,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    output logic [1:0]  req_ready,
    output logic [7:0]  pe_a,
    output logic [7:0]  pe_b,
    output logic        pe_clear,
    input  logic [7:0]  pe_acc,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [7:0]  rsp_data,
    output logic        rsp_err,
    input  logic        rsp_ready,
    output logic        busy
`ifdef PE_SCHED_PERF_EN
    ,
    output logic [15:0] job_cnt0,
    output logic [15:0] job_cnt1,
    output logic [15:0] busy_cycles
`endif
);

    localparam int unsigned CW = $clog2(MAX_LEN + 1);
    localparam int unsigned DW = (PIPE_LAT > 0) ? $clog2(PIPE_LAT + 1) : 1;
    localparam logic [CW-1:0] LAST_CNT  = CW'(MAX_LEN - 1);
    localparam logic [DW-1:0] DRAIN_END = DW'(PIPE_LAT);

    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, RESP} state_t;

    state_t        state, state_d;
    logic          gnt, gnt_d;
    logic          rr, rr_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [DW-1:0] drain, drain_d;
    logic          err, err_d;
    logic [7:0]    pe_a_d, pe_b_d;
    logic          pe_clear_d;
    logic          rsp_valid_d, rsp_id_d, rsp_err_d;
    logic [7:0]    rsp_data_d;
    logic [7:0]    a_sel, b_sel;
    logic          valid_sel, last_sel;

    assign a_sel     = gnt ? req_a[15:8] : req_a[7:0];
    assign b_sel     = gnt ? req_b[15:8] : req_b[7:0];
    assign valid_sel = req_valid[gnt];
    assign last_sel  = req_last[gnt];
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            gnt       <= 1'b0;
            rr        <= 1'b0;
            cnt       <= '0;
            drain     <= '0;
            err       <= 1'b0;
            pe_a      <= '0;
            pe_b      <= '0;
            pe_clear  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_d;
            gnt       <= gnt_d;
            rr        <= rr_d;
            cnt       <= cnt_d;
            drain     <= drain_d;
            err       <= err_d;
            pe_a      <= pe_a_d;
            pe_b      <= pe_b_d;
            pe_clear  <= pe_clear_d;
            rsp_valid <= rsp_valid_d;
            rsp_id    <= rsp_id_d;
            rsp_data  <= rsp_data_d;
            rsp_err   <= rsp_err_d;
        end
    end

    // PE-side outputs are registered, so each is computed one cycle ahead of the state it belongs to.
    always_comb begin
        state_d     = state;
        gnt_d       = gnt;
        rr_d        = rr;
        cnt_d       = cnt;
        drain_d     = drain;
        err_d       = err;
        pe_a_d      = '0;
        pe_b_d      = '0;
        pe_clear_d  = 1'b0;
        rsp_valid_d = rsp_valid;
        rsp_id_d    = rsp_id;
        rsp_data_d  = rsp_data;
        rsp_err_d   = rsp_err;
        req_ready   = '0;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    gnt_d      = (req_valid == 2'b11) ? rr : req_valid[1];
                    state_d    = CLEAR;
                    pe_clear_d = 1'b1;
                end
            end
            CLEAR: begin
                cnt_d   = '0;
                state_d = STREAM;
            end
            STREAM: begin
                req_ready[gnt] = 1'b1;
                if (valid_sel) begin
                    pe_a_d = a_sel;
                    pe_b_d = b_sel;
                    cnt_d  = cnt + 1'b1;
                    if (last_sel) begin
                        state_d = DRAIN;
                        err_d   = 1'b0;
                        drain_d = '0;
                    end else if (cnt == LAST_CNT) begin
                        state_d = DRAIN;
                        err_d   = 1'b1;
                        drain_d = '0;
                    end
                end
            end
            DRAIN: begin
                if (drain == DRAIN_END) begin
                    rsp_data_d  = pe_acc;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = gnt;
                    rsp_err_d   = err;
                    state_d     = RESP;
                end else begin
                    drain_d = drain + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rr_d        = ~gnt;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef PE_SCHED_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            job_cnt0    <= '0;
            job_cnt1    <= '0;
            busy_cycles <= '0;
        end else begin
            if (state == RESP && rsp_ready) begin
                if (!gnt && job_cnt0 != '1) job_cnt0 <= job_cnt0 + 1'b1;
                if (gnt && job_cnt1 != '1)  job_cnt1 <= job_cnt1 + 1'b1;
            end
            if (busy && busy_cycles != '1) busy_cycles <= busy_cycles + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pe_mac_scheduler.sv
// Directed bench for pe_mac_scheduler: external PE/accumulator model, job-level scoreboard,
// and literal expectations for each scenario.
module tb_pe_mac_scheduler;
    localparam int PIPE_LAT = 2;
    localparam int MAX_LEN  = 9;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid, req_last, req_ready;
    logic [15:0] req_a, req_b;
    logic [7:0]  pe_a, pe_b, pe_acc, rsp_data;
    logic        pe_clear, rsp_valid, rsp_id, rsp_err, rsp_ready, busy;
`ifdef PE_SCHED_PERF_EN
    logic [15:0] job_cnt0, job_cnt1, busy_cycles;
`endif

    logic       v0 = 1'b0, v1 = 1'b0, l0 = 1'b0, l1 = 1'b0;
    logic [7:0] a0 = '0, a1 = '0, b0 = '0, b1 = '0;
    assign req_valid = {v1, v0};
    assign req_last  = {l1, l0};
    assign req_a     = {a1, a0};
    assign req_b     = {b1, b0};

    pe_mac_scheduler #(.PIPE_LAT(PIPE_LAT), .MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_last(req_last), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready),
        .pe_a(pe_a), .pe_b(pe_b), .pe_clear(pe_clear), .pe_acc(pe_acc),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .rsp_ready(rsp_ready), .busy(busy)
`ifdef PE_SCHED_PERF_EN
        , .job_cnt0(job_cnt0), .job_cnt1(job_cnt1), .busy_cycles(busy_cycles)
`endif
    );

    always #5 clk = ~clk;

    // External PE: product register then accumulator; not reset, only pe_clear empties it.
    logic [7:0] prod_q = '0, acc_q = '0;
    always @(posedge clk) begin
        if (pe_clear) begin
            prod_q <= '0;
            acc_q  <= '0;
        end else begin
            prod_q <= 8'(pe_a * pe_b);
            acc_q  <= acc_q + prod_q;
        end
    end
    assign pe_acc = acc_q;

    typedef struct packed { logic id; logic [7:0] data; logic err; } rsp_t;
    rsp_t exp_q[$];
    rsp_t served_log[$];
    int   checks = 0, errors = 0, cyc = 0, served = 0;
    int   rise_cyc = -1;
    int   tally0 = 0, tally1 = 0;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc++;

    // Compare process: every cycle a response is presented it must match the oldest expected job.
    always @(negedge clk) begin
        if (!reset) begin
            if (req_ready != 2'b00) begin
                checks++;
                if (req_ready == 2'b11) begin
                    errors++;
                    $display("FAIL ready_onehot got=%b required one-hot", req_ready);
                end
            end
            if (rsp_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected got id=%0d data=%0d err=%0d", rsp_id, rsp_data, rsp_err);
                end else if (rsp_id !== exp_q[0].id || rsp_data !== exp_q[0].data || rsp_err !== exp_q[0].err) begin
                    errors++;
                    $display("FAIL rsp_match got id=%0d data=%0d err=%0d required id=%0d data=%0d err=%0d",
                             rsp_id, rsp_data, rsp_err, exp_q[0].id, exp_q[0].data, exp_q[0].err);
                end
                if (rsp_ready) begin
                    served_log.push_back('{id: rsp_id, data: rsp_data, err: rsp_err});
                    if (rsp_id) tally1++; else tally0++;
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    served++;
                end
            end
            if (rsp_valid && !prev_valid) rise_cyc = cyc;
        end
        prev_valid = rsp_valid;
    end

    task automatic chk(input string name, input int got, input int req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got=%0d required=%0d", name, got, req);
        end
    endtask

    task automatic chk_log(input string name, input int idx, input int id, input int data, input int err);
        checks++;
        if (served_log.size() <= idx) begin
            errors++;
            $display("FAIL %s missing response %0d (served=%0d)", name, idx, served_log.size());
        end else if (served_log[idx].id !== 1'(id) || served_log[idx].data !== 8'(data) || served_log[idx].err !== 1'(err)) begin
            errors++;
            $display("FAIL %s got id=%0d data=%0d err=%0d required id=%0d data=%0d err=%0d", name,
                     served_log[idx].id, served_log[idx].data, served_log[idx].err, id, data, err);
        end
    endtask

    task automatic drive(input int id, input bit v, input int a, input int b, input bit l);
        if (id == 0) begin v0 = v; a0 = 8'(a); b0 = 8'(b); l0 = l; end
        else         begin v1 = v; a1 = 8'(a); b1 = 8'(b); l1 = l; end
    endtask

    // Streams one job; expected result is pushed when the final beat is accepted.
    task automatic send_job(input int id, input int n, input int av[MAX_LEN], input int bv[MAX_LEN],
                            input bit last_en, input bit bubbles, output int t_first);
        int   k = 0;
        int   guard = 0;
        bit   gap = 1'b0;
        bit   acc;
        logic [7:0] sum = '0;
        rsp_t e;
        t_first = cyc;
        while (k < n && guard < 300) begin
            drive(id, !gap, av[k], bv[k], last_en && (k == n - 1));
            @(negedge clk);
            acc = !gap && req_ready[id];
            if (acc) begin
                sum = sum + 8'(av[k] * bv[k]);
                k++;
                if (k == n) begin
                    e.id   = 1'(id);
                    e.data = sum;
                    e.err  = !last_en && (n == MAX_LEN);
                    exp_q.push_back(e);
                end
            end
            if (bubbles && (acc || gap)) gap = !gap;
            guard++;
            @(posedge clk);
            #1;
        end
        drive(id, 1'b0, 0, 0, 1'b0);
        if (k < n) begin
            checks++;
            errors++;
            $display("FAIL send_timeout id=%0d accepted=%0d required=%0d", id, k, n);
        end else begin
            chk("ready_drop", int'(req_ready[id]), 0);
        end
    endtask

    task automatic wait_served(input int target, input string tag);
        int g = 0;
        while (served < target && g < 200) begin
            @(posedge clk);
            g++;
        end
        @(posedge clk);
        #1;
        chk({tag, "_served"}, served, target);
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, int'({req_ready, pe_a, pe_b, pe_clear, rsp_valid, rsp_id, rsp_data, rsp_err, busy}), 0);
    endtask

    int ones[MAX_LEN], twos[MAX_LEN], s16[MAX_LEN], s20[MAX_LEN], s7[MAX_LEN], s3[MAX_LEN];
    int seqa[MAX_LEN], seqb[MAX_LEN], bpa[MAX_LEN], bpb[MAX_LEN];
    int tA, tB, tf;

    initial begin
        for (int i = 0; i < MAX_LEN; i++) begin
            ones[i] = 1;  twos[i] = 2;  s16[i] = 16; s20[i] = 20;
            s7[i]   = 7;  s3[i]   = 3;
            seqa[i] = 2 * i + 1;  seqb[i] = 2 * i + 2;
            bpa[i]  = (i == 0) ? 10 : 4;  bpb[i] = (i == 0) ? 3 : 4;
        end
        reset = 1'b1;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset_outputs");
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Contention from reset: req0 favoured first, then req1.
        fork
            send_job(0, 9, ones, ones, 1'b1, 1'b0, tA);
            send_job(1, 9, twos, twos, 1'b1, 1'b0, tB);
        join
        wait_served(2, "contA");
        chk_log("contA_first", 0, 0, 9, 0);
        chk_log("contA_second", 1, 1, 36, 0);

        // Second contention after req1 was served: req0 again.
        fork
            send_job(0, 9, ones, ones, 1'b1, 1'b0, tA);
            send_job(1, 9, twos, twos, 1'b1, 1'b0, tB);
        join
        wait_served(4, "contB");
        chk_log("contB_first", 2, 0, 9, 0);
        chk_log("contB_second", 3, 1, 36, 0);

        // Single job (1,2),(3,4),(5,6); minimum latency 1+1+3+PIPE_LAT+1.
        send_job(0, 3, seqa, seqb, 1'b1, 1'b0, tf);
        wait_served(5, "single");
        chk_log("single_rsp", 4, 0, 44, 0);
        chk("single_latency", rise_cyc - tf, 8);
        chk("single_busy_after", int'(busy), 0);

        // After req0 alone, the pointer favours req1.
        fork
            send_job(0, 9, ones, ones, 1'b1, 1'b0, tA);
            send_job(1, 9, twos, twos, 1'b1, 1'b0, tB);
        join
        wait_served(7, "contC");
        chk_log("contC_first", 5, 1, 36, 0);
        chk_log("contC_second", 6, 0, 9, 0);

        send_job(0, 9, s16, ones, 1'b1, 1'b1, tf);
        wait_served(8, "bubble");
        chk_log("bubble_rsp", 7, 0, 144, 0);

        send_job(0, 9, s20, twos, 1'b0, 1'b0, tf);
        wait_served(9, "overflow");
        chk_log("overflow_rsp", 8, 0, 104, 1);

        // Back-pressure: response held stable while rsp_ready is low.
        rsp_ready = 1'b0;
        send_job(0, 2, bpa, bpb, 1'b1, 1'b0, tf);
        for (int g = 0; g < 50 && !rsp_valid; g++) begin
            @(posedge clk);
            #1;
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_valid_held", int'(rsp_valid), 1);
            chk("bp_data_held", int'(rsp_data), 46);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        wait_served(10, "bp");
        chk_log("bp_rsp", 9, 0, 46, 0);

        // Reset mid-DRAIN aborts req1's job; the following job must not see its partial sum.
        send_job(1, 4, s7, s7, 1'b1, 1'b0, tf);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk_all_zero("reset_mid_drain");
        exp_q.delete();
        tally0 = 0;
        tally1 = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        send_job(0, 2, s3, s3, 1'b1, 1'b0, tf);
        wait_served(11, "post_reset");
        chk_log("post_reset_rsp", 10, 0, 18, 0);
        chk("post_reset_busy", int'(busy), 0);
`ifdef PE_SCHED_PERF_EN
        chk("perf_job_cnt0", int'(job_cnt0), tally0);
        chk("perf_job_cnt1", int'(job_cnt1), tally1);
        chk("perf_busy_nonzero", int'(busy_cycles != 16'd0), 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

endmodule
